// File: rtl/trb_stream_reader_if.sv
// rtl/trb_stream_reader_if.sv - request, BRAM read-port and output-stream bundle for trb_stream_reader
//
// Signals:
//   req_valid/req_ready/req_addr/req_len  burst request handshake (len is ADDR_W+1 bits)
//   rd_addr/rd_data                       BRAM read port (data combinational from address)
//   dout_valid/dout_ready/dout_data/dout_last  output word stream
//   busy/err                              status: not idle / one-cycle reject pulse
// Modports: slave = the reader block, master = the requester/consumer/BRAM side.

interface trb_stream_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W:0]   req_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic              dout_last;
    logic              busy;
    logic              err;

    modport slave (
        input  req_valid, req_addr, req_len, rd_data, dout_ready,
        output req_ready, rd_addr, dout_valid, dout_data, dout_last, busy, err
    );

    modport master (
        output req_valid, req_addr, req_len, rd_data, dout_ready,
        input  req_ready, rd_addr, dout_valid, dout_data, dout_last, busy, err
    );
endinterface

// File: rtl/trb_stream_reader.sv
// rtl/trb_stream_reader.sv - trace BRAM burst reader with 2-entry skid buffer and valid/ready output
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    trb_stream_reader_if.slave: request handshake, BRAM read port, output stream, busy/err
// Parameters: ADDR_W (address width), DATA_W (word width), DEPTH (= 2**ADDR_W words).
// Optional feature macro: STB_TRB_READER_WRAP_EN - when defined, bursts may run past the
// top of the BRAM and wrap to address 0; when undefined such bursts are rejected with err.

module trb_stream_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trb_stream_reader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              last0_q, last0_d, last1_q, last1_d;
    logic              err_q, err_d;
    logic              push, pop, push_last, req_illegal;

`ifdef STB_TRB_READER_WRAP_EN
    always_comb begin
        req_illegal = (bus.req_len == '0) || ({1'b0, bus.req_len} > DEPTH_X);
    end
`else
    logic [ADDR_W+1:0] req_end;
    // One extra bit so addr+len never overflows before the range check.
    assign req_end = {2'b00, bus.req_addr} + {1'b0, bus.req_len};
    always_comb begin
        req_illegal = (bus.req_len == '0) || ({1'b0, bus.req_len} > DEPTH_X) || (req_end > DEPTH_X);
    end
`endif

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        err_d       = 1'b0;
        push        = 1'b0;
        pop         = (count_q != 2'd0) && bus.dout_ready;
        push_last   = (remaining_q == (ADDR_W+1)'(1));

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        rd_addr_d   = bus.req_addr;
                        remaining_d = bus.req_len;
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                // A full buffer can still take a word if the head leaves this cycle.
                if ((count_q != 2'd2) || pop) begin
                    push        = 1'b1;
                    rd_addr_d   = rd_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    if (push_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        if (push && !pop) begin
            if (count_q == 2'd0) begin
                data0_d = bus.rd_data;
                last0_d = push_last;
            end else begin
                data1_d = bus.rd_data;
                last1_d = push_last;
            end
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            data0_d = data1_q;
            last0_d = last1_q;
            count_d = count_q - 2'd1;
        end else if (push && pop) begin
            if (count_q == 2'd1) begin
                data0_d = bus.rd_data;
                last0_d = push_last;
            end else begin
                data0_d = data1_q;
                last0_d = last1_q;
                data1_d = bus.rd_data;
                last1_d = push_last;
            end
        end

        // Leave DRAIN as soon as the final word is popped so busy drops the next cycle.
        if ((state_q == DRAIN) && (count_d == 2'd0)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            count_q     <= 2'd0;
            data0_q     <= '0;
            data1_q     <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.rd_addr    = rd_addr_q;
    assign bus.dout_valid = (count_q != 2'd0);
    assign bus.dout_data  = data0_q;
    assign bus.dout_last  = last0_q && (count_q != 2'd0);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_trb_stream_reader.sv
// tb/tb_trb_stream_reader.sv - self-checking bench for trb_stream_reader

module tb_trb_stream_reader;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trb_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    trb_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    assign bus.rd_data = mem[bus.rd_addr];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [DATA_W-1:0] exp_word(input int addr, input int i);
        return mem[(addr + i) % DEPTH];
    endfunction

    task automatic send_req(input int addr, input int len);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = ADDR_W'(addr);
        bus.req_len   = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.req_valid = 1'b0; bus.dout_ready = 1'b0;
        bus.req_addr = '0; bus.req_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_vec++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid); end
        n_vec++; if (bus.dout_last !== 1'b0) begin n_err++; $display("FAIL reset_dout_last got=%b exp=0", bus.dout_last); end
        n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        n_vec++; if (bus.rd_addr !== '0) begin n_err++; $display("FAIL reset_rd_addr got=%0h exp=0", bus.rd_addr); end
        n_vec++; if (bus.dout_data !== '0) begin n_err++; $display("FAIL reset_dout_data got=%0h exp=0", bus.dout_data); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.dout_ready = 1'b1;
        send_req(16, 4);
        @(negedge clk);
        n_vec++; if (bus.rd_addr !== ADDR_W'(16)) begin n_err++; $display("FAIL basic_rd_addr got=%0h exp=10", bus.rd_addr); end
        n_vec++; if (bus.busy !== 1'b1 || bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL basic_c1 busy=%b valid=%b exp busy=1 valid=0", bus.busy, bus.dout_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== exp_word(16, k) || bus.dout_last !== (k == 3) || bus.busy !== 1'b1)
                begin n_err++; $display("FAIL basic_word%0d valid=%b data=%0h last=%b busy=%b exp 1/%0h/%b/1", k, bus.dout_valid, bus.dout_data, bus.dout_last, bus.busy, exp_word(16, k), (k == 3)); end
        end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0 || bus.req_ready !== 1'b1)
            begin n_err++; $display("FAIL basic_end busy=%b valid=%b ready=%b exp 0/0/1", bus.busy, bus.dout_valid, bus.req_ready); end
    endtask

    task automatic test_back_pressure();
        for (int b = 0; b < 8; b++) begin
            int len, addr, got, cyc;
            logic pv, pl;
            logic [DATA_W-1:0] pd;
            len  = (b == 0) ? 8 : int'($urandom_range(1, 12));
            addr = (b == 0) ? 5 : int'($urandom_range(0, DEPTH - len));
            bus.dout_ready = 1'b0;
            send_req(addr, len);
            got = 0; cyc = 0; pv = 1'b0; pl = 1'b0; pd = '0;
            while (got < len && cyc < 200) begin
                if (b == 0) bus.dout_ready = (cyc % 3 == 0) ? 1'b1 : 1'b0;
                else        bus.dout_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (pv) begin
                    n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== pd || bus.dout_last !== pl)
                        begin n_err++; $display("FAIL bp_hold b=%0d valid=%b data=%0h last=%b exp 1/%0h/%b", b, bus.dout_valid, bus.dout_data, bus.dout_last, pd, pl); end
                end
                if (bus.dout_valid === 1'b1) begin
                    if (bus.dout_ready) begin
                        n_vec++; if (bus.dout_data !== exp_word(addr, got) || bus.dout_last !== (got == len - 1))
                            begin n_err++; $display("FAIL bp_word b=%0d i=%0d data=%0h last=%b exp %0h/%b", b, got, bus.dout_data, bus.dout_last, exp_word(addr, got), (got == len - 1)); end
                        got++;
                    end
                    pv = !bus.dout_ready; pd = bus.dout_data; pl = bus.dout_last;
                end else begin
                    pv = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
            n_vec++; if (got != len) begin n_err++; $display("FAIL bp_count b=%0d got=%0d exp=%0d", b, got, len); end
            bus.dout_ready = 1'b1;
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0)
                begin n_err++; $display("FAIL bp_end b=%0d valid=%b busy=%b exp 0/0", b, bus.dout_valid, bus.busy); end
        end
    endtask

    task automatic test_zero_len();
        bus.dout_ready = 1'b1;
        send_req(5, 0);
        @(negedge clk);
        n_vec++; if (bus.err !== 1'b1 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0)
            begin n_err++; $display("FAIL zero_err err=%b ready=%b busy=%b exp 1/1/0", bus.err, bus.req_ready, bus.busy); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b0 || bus.err !== 1'b0 || bus.req_ready !== 1'b1)
                begin n_err++; $display("FAIL zero_quiet valid=%b err=%b ready=%b exp 0/0/1", bus.dout_valid, bus.err, bus.req_ready); end
        end
    endtask

    task automatic test_back_to_back();
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = ADDR_W'(3); bus.req_len = '0;
        @(posedge clk); #1;
        bus.req_addr = ADDR_W'(7); bus.req_len = (ADDR_W+1)'(2);
        @(negedge clk);
        n_vec++; if (bus.err !== 1'b1 || bus.req_ready !== 1'b1)
            begin n_err++; $display("FAIL b2b_err err=%b ready=%b exp 1/1", bus.err, bus.req_ready); end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.rd_addr !== ADDR_W'(7) || bus.busy !== 1'b1 || bus.err !== 1'b0)
            begin n_err++; $display("FAIL b2b_accept rd_addr=%0h busy=%b err=%b exp 7/1/0", bus.rd_addr, bus.busy, bus.err); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== exp_word(7, k) || bus.dout_last !== (k == 1))
                begin n_err++; $display("FAIL b2b_word%0d valid=%b data=%0h last=%b exp 1/%0h/%b", k, bus.dout_valid, bus.dout_data, bus.dout_last, exp_word(7, k), (k == 1)); end
        end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_end busy=%b exp 0", bus.busy); end
    endtask

    task automatic test_wrap();
        bus.dout_ready = 1'b1;
        send_req(DEPTH - 2, 4);
        @(negedge clk);
`ifdef STB_TRB_READER_WRAP_EN
        n_vec++; if (bus.err !== 1'b0 || bus.rd_addr !== ADDR_W'(DEPTH - 2))
            begin n_err++; $display("FAIL wrap_accept err=%b rd_addr=%0h exp 0/%0h", bus.err, bus.rd_addr, DEPTH - 2); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== exp_word(DEPTH - 2, k) || bus.dout_last !== (k == 3))
                begin n_err++; $display("FAIL wrap_word%0d valid=%b data=%0h last=%b exp 1/%0h/%b", k, bus.dout_valid, bus.dout_data, bus.dout_last, exp_word(DEPTH - 2, k), (k == 3)); end
        end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wrap_end busy=%b exp 0", bus.busy); end
`else
        n_vec++; if (bus.err !== 1'b1 || bus.busy !== 1'b0)
            begin n_err++; $display("FAIL wrap_reject err=%b busy=%b exp 1/0", bus.err, bus.busy); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b0) begin n_err++; $display("FAIL wrap_quiet valid=%b exp 0", bus.dout_valid); end
        end
`endif
    endtask

    task automatic test_full_depth();
        bus.dout_ready = 1'b1;
        send_req(0, DEPTH);
        @(negedge clk);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== exp_word(0, k) || bus.dout_last !== (k == DEPTH - 1))
                begin n_err++; $display("FAIL full_word%0d valid=%b data=%0h last=%b exp 1/%0h/%b", k, bus.dout_valid, bus.dout_data, bus.dout_last, exp_word(0, k), (k == DEPTH - 1)); end
        end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0)
            begin n_err++; $display("FAIL full_end busy=%b valid=%b exp 0/0", bus.busy, bus.dout_valid); end
        send_req(0, DEPTH + 1);
        @(negedge clk);
        n_vec++; if (bus.err !== 1'b1 || bus.busy !== 1'b0)
            begin n_err++; $display("FAIL over_len err=%b busy=%b exp 1/0", bus.err, bus.busy); end
        @(negedge clk);
        n_vec++; if (bus.dout_valid !== 1'b0 || bus.err !== 1'b0)
            begin n_err++; $display("FAIL over_len_quiet valid=%b err=%b exp 0/0", bus.dout_valid, bus.err); end
    endtask

    task automatic test_reset_mid();
        int pops, cyc;
        bus.dout_ready = 1'b1;
        send_req(3, 16);
        pops = 0; cyc = 0;
        while (pops < 5 && cyc < 40) begin
            @(negedge clk);
            if (bus.dout_valid === 1'b1) begin
                n_vec++; if (bus.dout_data !== exp_word(3, pops) || bus.dout_last !== 1'b0)
                    begin n_err++; $display("FAIL mid_word%0d data=%0h last=%b exp %0h/0", pops, bus.dout_data, bus.dout_last, exp_word(3, pops)); end
                pops++;
            end
            cyc++;
        end
        n_vec++; if (pops != 5) begin n_err++; $display("FAIL mid_pops got=%0d exp=5", pops); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dout_last !== 1'b0 || bus.rd_addr !== '0)
            begin n_err++; $display("FAIL mid_reset valid=%b busy=%b last=%b rd_addr=%0h exp 0/0/0/0", bus.dout_valid, bus.busy, bus.dout_last, bus.rd_addr); end
        @(posedge clk); #1 rst_n = 1'b1;
        send_req(9, 2);
        @(negedge clk);
        n_vec++; if (bus.rd_addr !== ADDR_W'(9)) begin n_err++; $display("FAIL mid_new_addr got=%0h exp=9", bus.rd_addr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++; if (bus.dout_valid !== 1'b1 || bus.dout_data !== exp_word(9, k) || bus.dout_last !== (k == 1))
                begin n_err++; $display("FAIL mid_new_word%0d valid=%b data=%0h last=%b exp 1/%0h/%b", k, bus.dout_valid, bus.dout_data, bus.dout_last, exp_word(9, k), (k == 1)); end
        end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_new_end busy=%b exp 0", bus.busy); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
        test_reset();
        test_basic();
        test_back_pressure();
        test_zero_len();
        test_back_to_back();
        test_wrap();
        test_full_depth();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
